// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the multi-entry FIFOs: clog2 plus pointer and count widths.
package fifo_pkg;

    localparam int MIN_DEPTH = 2;
    localparam int MAX_DEPTH = 256;

    // Accepted operations for one cycle, after full/empty gating has been applied
    typedef struct packed {
        logic enq;
        logic deq;
    } fifo_op_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // The count must be able to hold the value depth itself, hence depth+1
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sized_fifo_mem.sv
// Storage array for sized_fifo: one synchronous write port and one asynchronous read port.
module sized_fifo_mem #(
    parameter int width      = 0,
    parameter int depth      = 4,
    parameter int addr_width = 2
) (
    input  logic                  CLK,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [width:0]        wr_data,
    input  logic [addr_width-1:0] rd_addr,
    output logic [width:0]        rd_data
);

    logic [width:0] mem_array [depth];

    // Contents are deliberately not reset; count alone decides what is valid
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_array[rd_addr];

endmodule

// File: rtl/sized_fifo.sv
// Registered-only circular FIFO with a round-based consumed flag.
// Define SIZED_FIFO_OCCUPANCY_EN to expose the registered occupancy on COUNT.
module sized_fifo
    import fifo_pkg::*;
#(
    parameter int width = 0,
    parameter int depth = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ENQ,
    input  logic [width:0] ENQ_VALUE,
    output logic         NOT_FULL,
    output logic         CONSUMED_BEFORE,
    input  logic         RESET,
    output logic         CONSUMED,
    output logic         NOT_EMPTY,
    output logic [width:0] DEQ_VALUE,
    input  logic         DEQ
`ifdef SIZED_FIFO_OCCUPANCY_EN
    ,
    output logic [cnt_width(depth)-1:0] COUNT
`endif
);

    localparam int PTR_W = ptr_width(depth);
    localparam int CNT_W = cnt_width(depth);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(depth - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(depth);

    fifo_op_t         acc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             consumed;

    // Explicit wrap so non-power-of-2 depths never index past the last entry
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign NOT_FULL  = (count != FULL_COUNT);
    assign NOT_EMPTY = (count != '0);

    // RST gating keeps CONSUMED and the memory quiet while reset is held
    always_comb begin
        acc     = '0;
        acc.enq = ENQ && NOT_FULL && !RST;
        acc.deq = DEQ && NOT_EMPTY && !RST;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (acc.enq) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (acc.deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({acc.enq, acc.deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // RESET is the round strobe and outranks a same-cycle enqueue
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            consumed <= 1'b0;
        end else if (RESET) begin
            consumed <= 1'b0;
        end else if (acc.enq) begin
            consumed <= 1'b1;
        end
    end

    assign CONSUMED_BEFORE = consumed;
    assign CONSUMED        = acc.enq || consumed;

    sized_fifo_mem #(
        .width      (width),
        .depth      (depth),
        .addr_width (PTR_W)
    ) u_mem (
        .CLK     (CLK),
        .wr_en   (acc.enq),
        .wr_addr (wr_ptr),
        .wr_data (ENQ_VALUE),
        .rd_addr (rd_ptr),
        .rd_data (DEQ_VALUE)
    );

`ifdef SIZED_FIFO_OCCUPANCY_EN
    assign COUNT = count;
`endif

endmodule

// File: tb/tb_sized_fifo.sv
// Directed bench for sized_fifo: a depth-4 instance (A) and a depth-3 instance (B), both width=7.
// COUNT checks are compiled in when SIZED_FIFO_OCCUPANCY_EN is defined.
module tb_sized_fifo;

    logic       CLK = 1'b0;
    logic       RST;

    logic       a_enq, a_deq, a_reset;
    logic [7:0] a_enq_value;
    logic       a_not_full, a_not_empty, a_consumed, a_consumed_before;
    logic [7:0] a_deq_value;

    logic       b_enq, b_deq, b_reset;
    logic [7:0] b_enq_value;
    logic       b_not_full, b_not_empty, b_consumed, b_consumed_before;
    logic [7:0] b_deq_value;

`ifdef SIZED_FIFO_OCCUPANCY_EN
    logic [2:0] a_count;
    logic [1:0] b_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    sized_fifo #(.width(7), .depth(4)) u_dut_a (
        .CLK             (CLK),
        .RST             (RST),
        .ENQ             (a_enq),
        .ENQ_VALUE       (a_enq_value),
        .NOT_FULL        (a_not_full),
        .CONSUMED_BEFORE (a_consumed_before),
        .RESET           (a_reset),
        .CONSUMED        (a_consumed),
        .NOT_EMPTY       (a_not_empty),
        .DEQ_VALUE       (a_deq_value),
        .DEQ             (a_deq)
`ifdef SIZED_FIFO_OCCUPANCY_EN
        ,
        .COUNT           (a_count)
`endif
    );

    sized_fifo #(.width(7), .depth(3)) u_dut_b (
        .CLK             (CLK),
        .RST             (RST),
        .ENQ             (b_enq),
        .ENQ_VALUE       (b_enq_value),
        .NOT_FULL        (b_not_full),
        .CONSUMED_BEFORE (b_consumed_before),
        .RESET           (b_reset),
        .CONSUMED        (b_consumed),
        .NOT_EMPTY       (b_not_empty),
        .DEQ_VALUE       (b_deq_value),
        .DEQ             (b_deq)
`ifdef SIZED_FIFO_OCCUPANCY_EN
        ,
        .COUNT           (b_count)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        a_enq = 1'b1; a_deq = 1'b0; a_reset = 1'b0; a_enq_value = 8'hAA;
        b_enq = 1'b1; b_deq = 1'b0; b_reset = 1'b0; b_enq_value = 8'hBB;
        #2;
        vectors++; if (a_not_full !== 1'b1) begin $display("[TB] FAIL reset_a_not_full got %b want 1", a_not_full); miscompares++; end
        vectors++; if (a_not_empty !== 1'b0) begin $display("[TB] FAIL reset_a_not_empty got %b want 0", a_not_empty); miscompares++; end
        vectors++; if (a_consumed_before !== 1'b0) begin $display("[TB] FAIL reset_a_consumed_before got %b want 0", a_consumed_before); miscompares++; end
        vectors++; if (a_consumed !== 1'b0) begin $display("[TB] FAIL reset_a_consumed got %b want 0", a_consumed); miscompares++; end
        vectors++; if (b_not_full !== 1'b1) begin $display("[TB] FAIL reset_b_not_full got %b want 1", b_not_full); miscompares++; end
        vectors++; if (b_consumed !== 1'b0) begin $display("[TB] FAIL reset_b_consumed got %b want 0", b_consumed); miscompares++; end
`ifdef SIZED_FIFO_OCCUPANCY_EN
        vectors++; if (a_count !== 3'd0) begin $display("[TB] FAIL reset_a_count got %0d want 0", a_count); miscompares++; end
`endif
        tick();
        a_enq = 1'b0;
        b_enq = 1'b0;
        RST   = 1'b0;
        tick();
        vectors++; if (a_not_empty !== 1'b0) begin $display("[TB] FAIL post_reset_a_not_empty got %b want 0", a_not_empty); miscompares++; end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            a_enq = 1'b1;
            a_enq_value = vals[i];
            if (i == 0) begin
                #1;
                vectors++; if (a_not_empty !== 1'b0) begin $display("[TB] FAIL fill_no_bypass got %b want 0", a_not_empty); miscompares++; end
            end
            tick();
            if (i == 0) begin
                vectors++; if (a_deq_value !== 8'h11) begin $display("[TB] FAIL fill_first_latency got %h want 11", a_deq_value); miscompares++; end
            end
        end
        a_enq = 1'b0;
        vectors++; if (a_not_full !== 1'b0) begin $display("[TB] FAIL fill_not_full got %b want 0", a_not_full); miscompares++; end
        a_deq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (a_deq_value !== vals[i]) begin $display("[TB] FAIL drain_order[%0d] got %h want %h", i, a_deq_value, vals[i]); miscompares++; end
            tick();
        end
        a_deq = 1'b0;
        vectors++; if (a_not_empty !== 1'b0) begin $display("[TB] FAIL drain_not_empty got %b want 0", a_not_empty); miscompares++; end
        vectors++; if (a_not_full !== 1'b1) begin $display("[TB] FAIL drain_not_full got %b want 1", a_not_full); miscompares++; end
    endtask

    task automatic test_wrap_overflow();
        logic [7:0] w [5];
        logic [7:0] o [3];
        w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        o = '{8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 5; i++) begin
            b_enq = 1'b1;
            b_enq_value = w[i];
            tick();
            b_enq = 1'b0;
            vectors++; if (b_deq_value !== w[i]) begin $display("[TB] FAIL wrap_order[%0d] got %h want %h", i, b_deq_value, w[i]); miscompares++; end
            b_deq = 1'b1;
            tick();
            b_deq = 1'b0;
        end
        vectors++; if (b_not_empty !== 1'b0) begin $display("[TB] FAIL wrap_not_empty got %b want 0", b_not_empty); miscompares++; end
        for (int j = 0; j < 3; j++) begin
            b_enq = 1'b1;
            b_enq_value = o[j];
            tick();
        end
        b_enq_value = 8'hFF;
        vectors++; if (b_not_full !== 1'b0) begin $display("[TB] FAIL overflow_full got %b want 0", b_not_full); miscompares++; end
        tick();
        b_enq = 1'b0;
        vectors++; if (b_not_full !== 1'b0) begin $display("[TB] FAIL overflow_still_full got %b want 0", b_not_full); miscompares++; end
`ifdef SIZED_FIFO_OCCUPANCY_EN
        vectors++; if (b_count !== 2'd3) begin $display("[TB] FAIL overflow_count got %0d want 3", b_count); miscompares++; end
`endif
        b_deq = 1'b1;
        for (int j = 0; j < 3; j++) begin
            vectors++; if (b_deq_value !== o[j]) begin $display("[TB] FAIL overflow_data[%0d] got %h want %h", j, b_deq_value, o[j]); miscompares++; end
            tick();
        end
        b_deq = 1'b0;
        vectors++; if (b_not_empty !== 1'b0) begin $display("[TB] FAIL overflow_drained got %b want 0", b_not_empty); miscompares++; end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            a_enq = 1'b1;
            a_enq_value = 8'h51 + 8'(i);
            tick();
        end
        vectors++; if (a_not_full !== 1'b0) begin $display("[TB] FAIL simul_full_setup got %b want 0", a_not_full); miscompares++; end
        a_enq_value = 8'hEE;
        a_deq = 1'b1;
        tick();
        a_enq = 1'b0;
        vectors++; if (a_not_full !== 1'b1) begin $display("[TB] FAIL simul_full_count got %b want 1", a_not_full); miscompares++; end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (a_deq_value !== 8'h52 + 8'(i)) begin $display("[TB] FAIL simul_full_data[%0d] got %h want %h", i, a_deq_value, 8'h52 + 8'(i)); miscompares++; end
            tick();
        end
        vectors++; if (a_not_empty !== 1'b0) begin $display("[TB] FAIL simul_full_dropped got %b want 0", a_not_empty); miscompares++; end
        a_enq = 1'b1;
        a_enq_value = 8'h77;
        tick();
        a_enq = 1'b0;
        a_deq = 1'b0;
        vectors++; if (a_not_empty !== 1'b1) begin $display("[TB] FAIL simul_empty_count got %b want 1", a_not_empty); miscompares++; end
        vectors++; if (a_deq_value !== 8'h77) begin $display("[TB] FAIL simul_empty_data got %h want 77", a_deq_value); miscompares++; end
        a_deq = 1'b1;
        tick();
        a_deq = 1'b0;
        vectors++; if (a_not_empty !== 1'b0) begin $display("[TB] FAIL simul_empty_drain got %b want 0", a_not_empty); miscompares++; end
    endtask

    task automatic test_consumed();
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        vectors++; if (a_consumed_before !== 1'b0) begin $display("[TB] FAIL consumed_cleared got %b want 0", a_consumed_before); miscompares++; end
        tick();
        a_enq = 1'b1;
        a_enq_value = 8'h90;
        #1;
        vectors++; if (a_consumed !== 1'b1) begin $display("[TB] FAIL consumed_same_cycle got %b want 1", a_consumed); miscompares++; end
        vectors++; if (a_consumed_before !== 1'b0) begin $display("[TB] FAIL consumed_before_not_yet got %b want 0", a_consumed_before); miscompares++; end
        tick();
        a_enq = 1'b0;
        #1;
        vectors++; if (a_consumed_before !== 1'b1) begin $display("[TB] FAIL consumed_before_set got %b want 1", a_consumed_before); miscompares++; end
        tick();
        tick();
        a_reset = 1'b1;
        #1;
        vectors++; if (a_consumed_before !== 1'b1) begin $display("[TB] FAIL consumed_held got %b want 1", a_consumed_before); miscompares++; end
        tick();
        a_reset = 1'b0;
        #1;
        vectors++; if (a_consumed_before !== 1'b0) begin $display("[TB] FAIL consumed_round_clear got %b want 0", a_consumed_before); miscompares++; end
        vectors++; if (a_consumed !== 1'b0) begin $display("[TB] FAIL consumed_idle got %b want 0", a_consumed); miscompares++; end
        a_reset = 1'b1;
        a_enq = 1'b1;
        a_enq_value = 8'h91;
        #1;
        vectors++; if (a_consumed !== 1'b1) begin $display("[TB] FAIL consumed_reset_enq got %b want 1", a_consumed); miscompares++; end
        tick();
        a_reset = 1'b0;
        a_enq = 1'b0;
        #1;
        vectors++; if (a_consumed_before !== 1'b0) begin $display("[TB] FAIL consumed_reset_wins got %b want 0", a_consumed_before); miscompares++; end
    endtask

    task automatic test_async_reset();
        vectors++; if (a_not_empty !== 1'b1) begin $display("[TB] FAIL async_setup got %b want 1", a_not_empty); miscompares++; end
        #2;
        RST = 1'b1;
        #1;
        vectors++; if (a_not_empty !== 1'b0) begin $display("[TB] FAIL async_not_empty got %b want 0", a_not_empty); miscompares++; end
        vectors++; if (a_not_full !== 1'b1) begin $display("[TB] FAIL async_not_full got %b want 1", a_not_full); miscompares++; end
        tick();
        RST = 1'b0;
        a_enq = 1'b1;
        a_enq_value = 8'hC3;
        tick();
        a_enq = 1'b0;
        vectors++; if (a_not_empty !== 1'b1) begin $display("[TB] FAIL first_enq_after_reset got %b want 1", a_not_empty); miscompares++; end
        vectors++; if (a_deq_value !== 8'hC3) begin $display("[TB] FAIL first_enq_data got %h want c3", a_deq_value); miscompares++; end
        a_deq = 1'b1;
        tick();
        a_deq = 1'b0;
        vectors++; if (a_not_empty !== 1'b0) begin $display("[TB] FAIL async_final_drain got %b want 0", a_not_empty); miscompares++; end
    endtask

`ifdef SIZED_FIFO_OCCUPANCY_EN
    task automatic test_count();
        logic [2:0] expected [5];
        expected = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            vectors++; if (a_count !== expected[i]) begin $display("[TB] FAIL count_step[%0d] got %0d want %0d", i, a_count, expected[i]); miscompares++; end
            if (i < 4) begin
                a_enq = (i < 2);
                a_deq = (i >= 2);
                a_enq_value = 8'h60 + 8'(i);
                tick();
                a_enq = 1'b0;
                a_deq = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        $display("[TB] sized_fifo directed bench starting");
        test_reset();
        test_fill_drain();
        test_wrap_overflow();
        test_simultaneous();
        test_consumed();
        test_async_reset();
`ifdef SIZED_FIFO_OCCUPANCY_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
